dir_input_queue: RTL and testbench
==================================

// Module: dir_input_queue
// PURPOSE
//  Parametrised direction-input front end for the snake core. It replaces the single-register direction latch with per-button
//  synchronisation, debounce and press-edge detection, plus a small FIFO of pending turns.
//  The game core consumes one queued turn per movement step via tick, so quick double-taps (e.g. up-then-left) are not lost.
//  Sits between the board buttons and the game-logic block; dir output uses the UP/RIGHT/DOWN/LEFT encoding from define.vh.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000   consecutive stable cycles required before a button level is accepted (>=1)
//  CNT_W            16      debounce counter width; must hold DEBOUNCE_CYCLES
//  QUEUE_DEPTH      4       pending-turn FIFO entries (power of two, >=2)
//  PTR_W            2       log2(QUEUE_DEPTH)
//  ACTIVE_LOW       4'b1010 per-button polarity, bit=1 -> raw 0 means pressed; bit order {left,down,right,up}
//  INIT_DIR         `UP_DIR direction loaded on reset
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  btn_raw      in   4        raw asynchronous buttons {left,down,right,up}
//  tick         in   1        one-cycle game-step strobe; pops one queued turn
//  dir          out  2        current movement direction
//  queue_count  out  PTR_W+1  number of pending turns, 0..QUEUE_DEPTH
//  overflow     out  1        one-cycle pulse: valid press dropped because queue full
// BEHAVIOUR
//  Reset (async, rst_n=0): dir=INIT_DIR, queue empty, queue_count=0, overflow=0; sync FFs load the released level
//   (ACTIVE_LOW bit value); debounced state=released; counters=0. Outputs are registered.
//  Input path per channel: 2-FF synchroniser -> XOR ACTIVE_LOW (1=pressed) -> debounce -> rising-edge detect.
//  Debounce: counter clears while sync level == stable level; increments while different. The stable level flips on the
//   cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never flips it.
//  Press event: stable 0->1, one cycle. Release events are ignored.
//  Latency: raw edge held steady -> queue_count updates on clock edge DEBOUNCE_CYCLES+3 after the raw change.
//  Accept rule (cycle with press events):
//   - More than one channel presses in the same cycle -> all ignored, no overflow.
//   - Exactly one: candidate compared to ref = newest queue entry if non-empty, else dir.
//     Rejected silently if candidate == ref or candidate is the opposite of ref (no reversal, no duplicate).
//   - Accepted and not full -> enqueue at tail.
//  tick: if queue non-empty, dir <= head and head pops. If empty, dir holds.
//  Simultaneous tick + accepted push:
//   - Both occur; queue_count is unchanged.
//   - When full, the push is allowed because the pop frees the slot.
//   - With count==1, ref is the popped entry (it becomes dir).
//  Full, accepted push, no tick: entry dropped, overflow=1 for exactly that cycle, queue unchanged.
//  Pointers wrap modulo QUEUE_DEPTH; count saturates logically at QUEUE_DEPTH and never wraps.
//  Reset asserted mid-debounce or with entries queued: all state returns to reset values immediately.
//   Buttons still held after release of reset must re-debounce, and produce a press event only after DEBOUNCE_CYCLES.
// TESTING (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2, PTR_W=1, ACTIVE_LOW=0, INIT_DIR=`UP_DIR)
//  1 Press right, hold 10 cycles -> queue_count=1 at edge 7 after press; tick -> dir=`RIGHT_DIR, queue_count=0.
//  2 Right pulse of 3 cycles -> queue_count stays 0, no overflow (glitch rejected).
//  3 dir=UP, empty queue: press down -> rejected (reversal); press up -> rejected (duplicate); queue_count=0.
//  4 Press right, release, press down, release, press left, no tick ->
//     queue = [RIGHT, DOWN], overflow pulses once on the left press.
//    Next: tick -> dir=RIGHT, queue_count=1.
//  5 Right and left pressed on the same clock edge -> both ignored, queue_count=0; then queue full and a valid press
//     coincides with tick -> dir=head, new entry stored, queue_count stays 2, overflow=0.
//  6 Queue holds 1 entry, debounce counter mid-count; pull rst_n low -> dir=`UP_DIR, queue_count=0 immediately.
//    Keep button held after reset -> press accepted only after the full debounce latency.

Source files
------------

// File: rtl/dir_input_queue.sv
// Button front end: per-channel sync, debounce and press detection, then a FIFO of pending turns popped by tick.
// A press reaches queue_count DEBOUNCE_CYCLES+3 edges after the raw change; no backpressure, a full queue drops the press and pulses overflow.
module dir_input_queue #(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         CNT_W           = 16,
    parameter int         QUEUE_DEPTH     = 4,
    parameter int         PTR_W           = 2,
    parameter logic [3:0] ACTIVE_LOW      = 4'b1010,
    parameter logic [1:0] INIT_DIR        = 2'b00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       btn_raw,
    input  logic             tick,
    output logic [1:0]       dir,
    output logic [PTR_W:0]   queue_count,
    output logic             overflow
);

    // Direction code equals the button index: up=0, right=1, down=2, left=3.
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       sync_a;
    logic [3:0]       sync_b;
    logic [3:0]       level;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [3:0]       press;
    logic [CNT_W-1:0] db_cnt [4];

    logic [1:0]       queue_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_last;
    logic [1:0]       cand;
    logic [1:0]       ref_dir;
    logic             single;
    logic             accept;
    logic             full;
    logic             pop;
    logic             push;

    assign level = sync_b ^ ACTIVE_LOW;
    assign press = stable & ~stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a   <= ACTIVE_LOW;
            sync_b   <= ACTIVE_LOW;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_a   <= btn_raw;
            sync_b   <= sync_a;
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (level[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= level[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        cand = '0;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) begin
                cand = 2'(i);
            end
        end
    end

    // With one entry queued the newest entry is also the head, so a coincident pop keeps the reference correct.
    assign tail_last = tail - PTR_W'(1);
    assign ref_dir   = (queue_count == '0) ? dir : queue_mem[tail_last];
    assign single    = $onehot(press);
    assign accept    = single && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
    assign full      = (queue_count == DEPTH_CNT);
    assign pop       = tick && (queue_count != '0);
    assign push      = accept && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir         <= INIT_DIR;
            head        <= '0;
            tail        <= '0;
            queue_count <= '0;
            overflow    <= 1'b0;
        end else begin
            overflow <= accept && full && !pop;
            if (pop) begin
                dir  <= queue_mem[head];
                head <= head + PTR_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (push && !pop) begin
                queue_count <= queue_count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                queue_count <= queue_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            queue_mem[tail] <= cand;
        end
    end

endmodule

// File: tb/tb_dir_input_queue.sv
// Bench for dir_input_queue: directed scenarios plus random button/tick traffic checked every edge against a queue-based model.
module tb_dir_input_queue;

    localparam int         D     = 4;
    localparam int         DEPTH = 2;
    localparam logic [3:0] AL    = 4'b0000;
    localparam logic [1:0] UP = 2'd0, RIGHT = 2'd1, DOWN = 2'd2, LEFT = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'b0000;
    logic       tick = 1'b0;
    logic [1:0] dir;
    logic [1:0] queue_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int ovf_seen = 0;

    always #5 clk = ~clk;

    dir_input_queue #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(4),
        .QUEUE_DEPTH(DEPTH),
        .PTR_W(1),
        .ACTIVE_LOW(AL),
        .INIT_DIR(UP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .tick(tick),
        .dir(dir),
        .queue_count(queue_count),
        .overflow(overflow)
    );

    // Reference model: raw history per edge, run lengths of disagreement, and a plain queue of turns.
    logic [3:0] m_hist[$];
    logic [3:0] m_stable;
    logic [3:0] m_pend;
    int         m_run[4];
    logic [1:0] m_dir;
    logic [1:0] m_q[$];
    logic       m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            default: return RIGHT;
        endcase
    endfunction

    task automatic model_reset();
        m_hist.delete();
        m_hist.push_back(4'b0000);
        m_hist.push_back(4'b0000);
        m_stable = '0;
        m_pend   = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_dir = UP;
        m_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic t);
        logic [1:0] cand;
        logic [1:0] refd;
        logic [3:0] lvl;
        logic [3:0] new_press;
        bit acc, full, pop;
        cand = '0;
        for (int i = 0; i < 4; i++) if (m_pend[i]) cand = 2'(i);
        refd  = (m_q.size() > 0) ? m_q[$] : m_dir;
        acc   = ($countones(m_pend) == 1) && (cand != refd) && (cand != opposite(refd));
        full  = (m_q.size() == DEPTH);
        pop   = t && (m_q.size() > 0);
        m_ovf = 1'b0;
        if (pop) m_dir = m_q.pop_front();
        if (acc) begin
            if (!full || pop) m_q.push_back(cand);
            else m_ovf = 1'b1;
        end
        // The level the debouncer sees at this edge is the raw value sampled two edges earlier.
        lvl = m_hist[m_hist.size() - 2];
        new_press = '0;
        for (int i = 0; i < 4; i++) begin
            if (lvl[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_stable[i] = lvl[i];
                    m_run[i] = 0;
                    if (lvl[i]) new_press[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_pend = new_press;
        m_hist.push_back(raw ^ AL);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
    endtask

    task automatic step(input logic [3:0] raw, input logic t);
        btn_raw = raw;
        tick    = t;
        @(posedge clk);
        model_edge(raw, t);
        #1;
        chk("dir", 32'(dir), 32'(m_dir));
        chk("count", 32'(queue_count), 32'(m_q.size()));
        chk("ovf", 32'(overflow), 32'(m_ovf));
        if (overflow) ovf_seen++;
    endtask

    task automatic hold(input logic [3:0] raw, input int n);
        repeat (n) step(raw, 1'b0);
    endtask

    task automatic apply_reset(input logic [3:0] raw);
        btn_raw = raw;
        tick    = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_reset();
        chk("rst_dir", 32'(dir), 32'(UP));
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] cur;
        int         left_hold;
        int         r;

        model_reset();
        #2;
        apply_reset(4'b0000);

        // Single press latency and tick consumption.
        hold(4'b0010, 6);
        chk("t1_edge6_count", 32'(queue_count), 32'd0);
        step(4'b0010, 1'b0);
        chk("t1_edge7_count", 32'(queue_count), 32'd1);
        hold(4'b0010, 3);
        hold(4'b0000, 2);
        step(4'b0000, 1'b1);
        chk("t1_tick_dir", 32'(dir), 32'(RIGHT));
        chk("t1_tick_count", 32'(queue_count), 32'd0);

        // Glitch one cycle short of the debounce window, then exactly the window.
        apply_reset(4'b0000);
        hold(4'b0010, 3);
        hold(4'b0000, 10);
        chk("t2_glitch_count", 32'(queue_count), 32'd0);
        hold(4'b0010, 4);
        hold(4'b0000, 8);
        chk("t2_min_pulse_count", 32'(queue_count), 32'd1);

        // Reversal and duplicate rejection.
        apply_reset(4'b0000);
        hold(4'b0100, 8);
        hold(4'b0000, 4);
        hold(4'b0001, 8);
        hold(4'b0000, 4);
        chk("t3_reject_count", 32'(queue_count), 32'd0);

        // Fill to full, third press overflows.
        apply_reset(4'b0000);
        ovf_seen = 0;
        hold(4'b0010, 6); hold(4'b0000, 6);
        hold(4'b0100, 6); hold(4'b0000, 6);
        hold(4'b1000, 6); hold(4'b0000, 6);
        chk("t4_full_count", 32'(queue_count), 32'd2);
        chk("t4_ovf_pulses", 32'(ovf_seen), 32'd1);
        step(4'b0000, 1'b1);
        chk("t4_tick_dir", 32'(dir), 32'(RIGHT));
        chk("t4_tick_count", 32'(queue_count), 32'd1);

        // Simultaneous presses ignored; push coinciding with tick when full.
        apply_reset(4'b0000);
        hold(4'b1010, 6); hold(4'b0000, 6);
        chk("t5_multi_count", 32'(queue_count), 32'd0);
        hold(4'b0010, 6); hold(4'b0000, 6);
        hold(4'b0100, 6); hold(4'b0000, 6);
        hold(4'b1000, 6);
        step(4'b1000, 1'b1);
        chk("t5_pushpop_dir", 32'(dir), 32'(RIGHT));
        chk("t5_pushpop_count", 32'(queue_count), 32'd2);
        chk("t5_pushpop_ovf", 32'(overflow), 32'd0);
        hold(4'b0000, 6);

        // Reset with an entry queued and a debounce in progress; held button must re-debounce.
        apply_reset(4'b0000);
        hold(4'b0010, 7);
        hold(4'b0000, 6);
        hold(4'b1000, 3);
        apply_reset(4'b1000);
        hold(4'b1000, 6);
        chk("t6_edge6_count", 32'(queue_count), 32'd0);
        step(4'b1000, 1'b0);
        chk("t6_edge7_count", 32'(queue_count), 32'd1);
        hold(4'b0000, 6);

        // Random traffic against the model.
        cur = 4'b0000;
        left_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (left_hold == 0) begin
                r = $urandom_range(0, 9);
                if (r <= 5) cur = 4'b0001 << $urandom_range(0, 3);
                else if (r <= 7) cur = 4'b0000;
                else cur = 4'($urandom_range(0, 15));
                left_hold = $urandom_range(1, 9);
            end
            left_hold--;
            if ($urandom_range(0, 999) == 0) apply_reset(cur);
            step(cur, ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
